// File: rtl/i2c_slave.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection, ACKed writes, serialized reads.
// Latency: bus pin to internal event 3 clk, SDA updates 4 clk after SCL falls; no backpressure, local side must keep pace.
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h55
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] r_data,
    output logic       r_req,
    output logic [7:0] w_data,
    output logic       w_valid,
    output logic       selected,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK
    } state_t;

    logic   scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_prev_q, scl_prev_d;
    logic   sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_prev_q, sda_prev_d;
    logic   fall_q, fall_d;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic   rw_q, rw_d;
    logic   sda_oe_q, sda_oe_d;
    logic [7:0] w_data_q, w_data_d;
    logic   w_valid_q, w_valid_d;
    logic   r_req_q, r_req_d;
    logic   selected_q, selected_d;
    logic   busy_q, busy_d;

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign sda_rise  = sda_sync_q & ~sda_prev_q;
    assign sda_fall  = ~sda_sync_q & sda_prev_q;
    assign start_det = sda_fall & scl_sync_q;
    assign stop_det  = sda_rise & scl_sync_q;

    always_comb begin
        scl_meta_d = i2c_scl;
        scl_sync_d = scl_meta_q;
        scl_prev_d = scl_sync_q;
        sda_meta_d = i2c_sda;
        sda_sync_d = sda_meta_q;
        sda_prev_d = sda_sync_q;
        // SDA is only changed one cycle after the falling edge is seen, giving hold time on the bus.
        fall_d     = scl_fall;
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        w_data_d   = w_data_q;
        w_valid_d  = 1'b0;
        r_req_d    = 1'b0;
        selected_d = selected_q;
        busy_d     = busy_q;

        if (r_req_q) shift_d = r_data;

        case (state_q)
            ST_ADDR: begin
                if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_sync_q};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        rw_d  = sda_sync_q;
                        if (shift_q[6:0] == ADDR) begin
                            state_d    = ST_ADDR_ACK;
                            selected_d = 1'b1;
                            r_req_d    = sda_sync_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_ADDR_ACK, ST_WRITE_ACK: begin
                // cnt 0: waiting for the 8th fall to start ACK; cnt 1: 9th rise seen, release on next fall.
                if (scl_rise) cnt_d = cnt_q + 4'd1;
                if (fall_q) begin
                    if (cnt_q == 4'd0) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        cnt_d = 4'd0;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d  = ST_READ;
                            sda_oe_d = ~shift_q[7];
                        end else begin
                            state_d  = ST_WRITE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_sync_q};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d     = 4'd0;
                        w_data_d  = {shift_q[6:0], sda_sync_q};
                        w_valid_d = 1'b1;
                        state_d   = ST_WRITE_ACK;
                    end
                end
            end
            ST_READ: begin
                if (scl_rise) cnt_d = cnt_q + 4'd1;
                if (fall_q) begin
                    if (cnt_q == 4'd8) begin
                        state_d  = ST_READ_ACK;
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        sda_oe_d = ~shift_q[7];
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
            end
            ST_READ_ACK: begin
                if (scl_rise) begin
                    cnt_d = 4'd0;
                    if (!sda_sync_q) begin
                        state_d = ST_READ;
                        r_req_d = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        selected_d = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase

        if (start_det) begin
            state_d    = ST_ADDR;
            cnt_d      = 4'd0;
            shift_d    = 8'h00;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b1;
            selected_d = 1'b0;
            r_req_d    = 1'b0;
        end
        if (stop_det) begin
            state_d    = ST_IDLE;
            cnt_d      = 4'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            selected_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            w_data_q   <= 8'h00;
            w_valid_q  <= 1'b0;
            r_req_q    <= 1'b0;
            selected_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_prev_q <= sda_prev_d;
            fall_q     <= fall_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            w_data_q   <= w_data_d;
            w_valid_q  <= w_valid_d;
            r_req_q    <= r_req_d;
            selected_q <= selected_d;
            busy_q     <= busy_d;
        end
    end

    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign w_data   = w_data_q;
    assign w_valid  = w_valid_q;
    assign r_req    = r_req_q;
    assign selected = selected_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C master driver plus transaction-level expectations.
// Each SCL phase is 10 clk; master changes SDA 6 clk after SCL falls, so every slave-held bit spans 20 clk.
module tb_i2c_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       scl_drv;
    logic       sda_drv_low;
    logic [7:0] r_data;
    wire        sda;
    wire        r_req;
    wire  [7:0] w_data;
    wire        w_valid;
    wire        selected;
    wire        busy;

    assign sda = sda_drv_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.ADDR(7'h55)) dut (
        .clk(clk), .reset(reset), .i2c_scl(scl_drv), .i2c_sda(sda),
        .r_data(r_data), .r_req(r_req), .w_data(w_data), .w_valid(w_valid),
        .selected(selected), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int slave_low, r_req_cnt, sel_cnt, busy_low;
    logic [7:0] wq[$];
    logic [7:0] rd_q[$];

    // Bus/handshake observers, sampled on the falling clock edge.
    initial forever begin
        @(negedge clk);
        if (sda === 1'b0 && !sda_drv_low) slave_low++;
        if (w_valid) wq.push_back(w_data);
        if (selected) sel_cnt++;
        if (!busy) busy_low++;
        if (r_req) begin
            r_req_cnt++;
            if (rd_q.size() > 0) r_data = rd_q.pop_front();
        end
    end

    function automatic int zeros(input logic [7:0] v);
        return 8 - $countones(v);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        slave_low = 0; r_req_cnt = 0; sel_cnt = 0; busy_low = 0;
        wq.delete();
    endtask

    task automatic send_bit(input logic b);
        wait_cyc(6); sda_drv_low = ~b;
        wait_cyc(4); scl_drv = 1'b1;
        wait_cyc(10); scl_drv = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        sda_drv_low = 1'b0;
        wait_cyc(10); scl_drv = 1'b1;
        wait_cyc(5);  b = (sda === 1'b0) ? 1'b0 : 1'b1;
        wait_cyc(5);  scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] v);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bt);
            v[i] = bt;
        end
        send_bit(mack);
    endtask

    task automatic do_start();
        if (scl_drv == 1'b0) begin
            wait_cyc(6); sda_drv_low = 1'b0;
            wait_cyc(4); scl_drv = 1'b1;
        end
        wait_cyc(10); sda_drv_low = 1'b1;
        wait_cyc(10); scl_drv = 1'b0;
    endtask

    task automatic do_stop();
        wait_cyc(6); sda_drv_low = 1'b1;
        wait_cyc(4); scl_drv = 1'b1;
        wait_cyc(10); sda_drv_low = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_reset();
        reset = 1'b1; scl_drv = 1'b1; sda_drv_low = 1'b0; r_data = 8'h00;
        wait_cyc(4);
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
        checks++; if (w_data !== 8'h00) begin failures++; $display("FAIL reset_w_data got=%h exp=00", w_data); end
        checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL reset_w_valid got=%b exp=0", w_valid); end
        checks++; if (r_req !== 1'b0) begin failures++; $display("FAIL reset_r_req got=%b exp=0", r_req); end
        checks++; if (selected !== 1'b0) begin failures++; $display("FAIL reset_selected got=%b exp=0", selected); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_write_match();
        logic a0, a1;
        clear_mon();
        do_start();
        send_byte(8'hAA, a0);
        checks++; if (selected !== 1'b1) begin failures++; $display("FAIL wr_selected got=%b exp=1", selected); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
        send_byte(8'hAA, a1);
        do_stop();
        checks++; if (a0 !== 1'b0) begin failures++; $display("FAIL wr_addr_ack got=%b exp=0", a0); end
        checks++; if (a1 !== 1'b0) begin failures++; $display("FAIL wr_data_ack got=%b exp=0", a1); end
        checks++; if (slave_low != 40) begin failures++; $display("FAIL wr_ack_cycles got=%0d exp=40", slave_low); end
        checks++; if (wq.size() != 1) begin failures++; $display("FAIL wr_wvalid_count got=%0d exp=1", wq.size()); end
        else begin
            checks++; if (wq[0] !== 8'hAA) begin failures++; $display("FAIL wr_wdata got=%h exp=aa", wq[0]); end
        end
        checks++; if (busy !== 1'b0 || selected !== 1'b0) begin failures++; $display("FAIL wr_after_stop got=%b%b exp=00", busy, selected); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        clear_mon();
        do_start();
        send_byte(8'h54, a0);
        send_byte(8'h11, a1);
        do_stop();
        checks++; if (a0 !== 1'b1 || a1 !== 1'b1) begin failures++; $display("FAIL mm_acks got=%b%b exp=11", a0, a1); end
        checks++; if (slave_low != 0) begin failures++; $display("FAIL mm_sda_low got=%0d exp=0", slave_low); end
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL mm_wvalid got=%0d exp=0", wq.size()); end
        checks++; if (sel_cnt != 0) begin failures++; $display("FAIL mm_selected got=%0d exp=0", sel_cnt); end
    endtask

    task automatic test_read_single();
        logic a; logic [7:0] v;
        clear_mon();
        rd_q.push_back(8'h01);
        do_start();
        send_byte(8'hAB, a);
        checks++; if (selected !== 1'b1) begin failures++; $display("FAIL rd1_selected got=%b exp=1", selected); end
        recv_byte(1'b1, v);
        checks++; if (selected !== 1'b0) begin failures++; $display("FAIL rd1_sel_after_nack got=%b exp=0", selected); end
        do_stop();
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL rd1_addr_ack got=%b exp=0", a); end
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL rd1_data got=%h exp=01", v); end
        checks++; if (r_req_cnt != 1) begin failures++; $display("FAIL rd1_rreq got=%0d exp=1", r_req_cnt); end
        checks++; if (slave_low != 20 * (1 + zeros(8'h01))) begin failures++; $display("FAIL rd1_sda_low got=%0d exp=%0d", slave_low, 20 * (1 + zeros(8'h01))); end
    endtask

    task automatic test_read_multi();
        logic a; logic [7:0] v0, v1;
        clear_mon();
        rd_q.push_back(8'hA5); rd_q.push_back(8'h3C);
        do_start();
        send_byte(8'hAB, a);
        recv_byte(1'b0, v0);
        recv_byte(1'b1, v1);
        do_stop();
        checks++; if (v0 !== 8'hA5) begin failures++; $display("FAIL rdm_byte0 got=%h exp=a5", v0); end
        checks++; if (v1 !== 8'h3C) begin failures++; $display("FAIL rdm_byte1 got=%h exp=3c", v1); end
        checks++; if (r_req_cnt != 2) begin failures++; $display("FAIL rdm_rreq got=%0d exp=2", r_req_cnt); end
        checks++; if (slave_low != 20 * (1 + zeros(8'hA5) + zeros(8'h3C))) begin failures++; $display("FAIL rdm_sda_low got=%0d exp=%0d", slave_low, 20 * (1 + zeros(8'hA5) + zeros(8'h3C))); end
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2; logic [7:0] v;
        clear_mon();
        rd_q.push_back(8'hFF);
        do_start();
        send_byte(8'hAA, a0);
        busy_low = 0;
        send_byte(8'h10, a1);
        do_start();
        send_byte(8'hAB, a2);
        recv_byte(1'b1, v);
        checks++; if (busy_low != 0) begin failures++; $display("FAIL rs_busy_drop got=%0d exp=0", busy_low); end
        do_stop();
        checks++; if (a0 !== 1'b0 || a1 !== 1'b0 || a2 !== 1'b0) begin failures++; $display("FAIL rs_acks got=%b%b%b exp=000", a0, a1, a2); end
        checks++; if (wq.size() != 1) begin failures++; $display("FAIL rs_wvalid_count got=%0d exp=1", wq.size()); end
        else begin
            checks++; if (wq[0] !== 8'h10) begin failures++; $display("FAIL rs_wdata got=%h exp=10", wq[0]); end
        end
        checks++; if (v !== 8'hFF) begin failures++; $display("FAIL rs_read got=%h exp=ff", v); end
        checks++; if (r_req_cnt != 1) begin failures++; $display("FAIL rs_rreq got=%0d exp=1", r_req_cnt); end
    endtask

    task automatic test_abort_stop();
        logic a;
        clear_mon();
        do_start();
        send_byte(8'hAA, a);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        do_stop();
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL ab_wvalid got=%0d exp=0", wq.size()); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL ab_sda got=%b exp=1", sda); end
        checks++; if (slave_low != 20) begin failures++; $display("FAIL ab_sda_low got=%0d exp=20", slave_low); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_ack();
        logic [7:0] ab;
        ab = 8'hAA;
        clear_mon();
        do_start();
        for (int i = 7; i >= 0; i--) send_bit(ab[i]);
        sda_drv_low = 1'b0;
        wait_cyc(10); scl_drv = 1'b1;
        wait_cyc(3);
        checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rst_pre_ack got=%b exp=0", sda); end
        reset = 1'b1;
        wait_cyc(1);
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rst_sda got=%b exp=1", sda); end
        checks++; if (busy !== 1'b0 || selected !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", busy, selected); end
        checks++; if (w_data !== 8'h00 || w_valid !== 1'b0 || r_req !== 1'b0) begin failures++; $display("FAIL rst_outputs got=%h%b%b exp=0000", w_data, w_valid, r_req); end
        reset = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [6:0] a; logic match, rw, ack; int n; int exp_low;
            logic [7:0] bytes[4]; logic [7:0] v, exp_v;
            match = 1'($urandom_range(0, 1));
            a = match ? 7'h55 : 7'($urandom_range(0, 127));
            if (!match && a == 7'h55) a = 7'h2A;
            rw = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
            clear_mon();
            rd_q.delete();
            if (match && rw) for (int k = 0; k < n; k++) rd_q.push_back(bytes[k]);
            exp_low = match ? 20 : 0;
            do_start();
            send_byte({a, rw}, ack);
            checks++; if (ack !== !match) begin failures++; $display("FAIL rnd%0d_addr_ack got=%b exp=%b", it, ack, !match); end
            for (int k = 0; k < n; k++) begin
                if (!rw) begin
                    send_byte(bytes[k], ack);
                    if (match) exp_low += 20;
                    checks++; if (ack !== !match) begin failures++; $display("FAIL rnd%0d_data_ack got=%b exp=%b", it, ack, !match); end
                end else begin
                    recv_byte(k == n - 1, v);
                    exp_v = match ? bytes[k] : 8'hFF;
                    if (match) exp_low += 20 * zeros(bytes[k]);
                    checks++; if (v !== exp_v) begin failures++; $display("FAIL rnd%0d_read got=%h exp=%h", it, v, exp_v); end
                end
            end
            do_stop();
            checks++; if (slave_low != exp_low) begin failures++; $display("FAIL rnd%0d_sda_low got=%0d exp=%0d", it, slave_low, exp_low); end
            checks++; if (wq.size() != ((match && !rw) ? n : 0)) begin failures++; $display("FAIL rnd%0d_wcount got=%0d exp=%0d", it, wq.size(), (match && !rw) ? n : 0); end
            else begin
                for (int k = 0; k < wq.size(); k++) begin
                    checks++; if (wq[k] !== bytes[k]) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", it, wq[k], bytes[k]); end
                end
            end
            checks++; if (r_req_cnt != ((match && rw) ? n : 0)) begin failures++; $display("FAIL rnd%0d_rreq got=%0d exp=%0d", it, r_req_cnt, (match && rw) ? n : 0); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd%0d_busy got=%b exp=0", it, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_write_match();
        test_addr_mismatch();
        test_read_single();
        test_read_multi();
        test_repeated_start();
        test_abort_stop();
        test_reset_ack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
